psram_req_responder: RTL
========================

// Module: psram_req_responder
// PURPOSE
//  clk64-domain responder for the strobe/busy request protocol driven from the clk32 side.
//  Accepts one-cycle read_in/write_in strobes with a 16-bit word address and data.
//  Converts each request into one burst command on the 32-bit PSRAM controller port.
//  Raises busy_out for the whole transaction and returns read data on dout_out.
// PARAMETERS
//  BURST_BEATS  4    32-bit data beats per controller burst (2..8)
//  CMD_GAP      14   idle cycles enforced after a burst, before busy_out drops (>=1)
//  RD_TIMEOUT   255  max cycles from read cmd_en to first rd_data_valid_in (8-bit counter)
// PORTS
//  clk64            in   1   64MHz clock; only clock of the block
//  resetn           in   1   asynchronous active-low reset
//  read_in          in   1   read request strobe (1 cycle, already synchronised)
//  write_in         in   1   write request strobe (1 cycle, already synchronised)
//  addr_in          in   22  16-bit word address, sampled on strobe
//  din_in           in   16  write data, sampled on strobe
//  busy_out         out  1   transaction in progress / controller not ready
//  dout_out         out  16  read data; valid from busy_out falling until next read
//  overrun_out      out  1   sticky: strobe arrived while busy_out=1
//  timeout_out      out  1   sticky: read saw no rd_data_valid_in within RD_TIMEOUT
//  calib_in         in   1   controller init/calibration done
//  cmd_out          out  1   0=read, 1=write; meaningful with cmd_en_out
//  cmd_en_out       out  1   1-cycle command strobe
//  ctl_addr_out     out  21  controller 32-bit-word address = addr_in[21:1]
//  wr_data_out      out  32  write beat data
//  data_mask_out    out  4   byte mask, 1 = byte NOT written
//  rd_data_in       in   32  read beat data
//  rd_data_valid_in in   1   read beat valid
// BEHAVIOUR
//  Reset: state INIT, busy_out=1, dout_out=0, overrun/timeout=0, cmd_en_out=0, cmd_out=0,
//   ctl_addr_out=0, wr_data_out=0, data_mask_out=4'hF, all counters 0.
//  States: INIT -> IDLE -> (WR_BURST | RD_WAIT -> RD_BURST) -> GAP -> IDLE.
//  INIT: busy_out=1; leave to IDLE the cycle after calib_in seen high; busy_out=0 on entry.
//  IDLE: read_in wins if both strobes high in the same cycle (write dropped, overrun set).
//   Strobe in cycle N: at N+1 cmd_en_out=1 (one cycle), ctl_addr_out=addr_in[21:1], busy_out=1.
//  Halfword select: addr_in[0]=0 -> bits [15:0], addr_in[0]=1 -> bits [31:16].
//  WR_BURST: beats on N+1..N+BURST_BEATS; beat 0: wr_data_out={din,din},
//   data_mask_out = addr[0] ? 4'b0011 : 4'b1100; beats 1..: data_mask_out=4'hF.
//   After last beat -> GAP; data_mask_out returns to 4'hF.
//  RD_WAIT: timer counts from cmd_en; first rd_data_valid_in -> capture selected half into
//   dout_out, go RD_BURST. Timer reaching RD_TIMEOUT -> timeout_out=1, dout_out unchanged, GAP.
//  RD_BURST: count valid beats incl. first; after BURST_BEATS valid beats -> GAP. Extra beats
//   outside RD_WAIT/RD_BURST ignored.
//  GAP: CMD_GAP cycles, then IDLE with busy_out=0 the same cycle. busy_out is therefore high
//   >= BURST_BEATS+CMD_GAP cycles, so the clk32 side always samples the rising edge.
//  Strobes in any state other than IDLE: ignored, overrun_out=1. Sticky flags clear only on reset.
//  calib_in falling outside INIT: ignored.
//  resetn low mid-transaction: immediate return to reset values; burst abandoned, no cmd issued.
// TESTING
//  calib_in low 20 cycles then high -> busy_out=1 throughout, drops 1 cycle after calib_in rise.
//  write addr=22'h000003 din=16'hBEEF -> cmd_en@N+1, cmd_out=1, ctl_addr=21'h000001,
//   beat0 wr_data=32'hBEEFBEEF mask=4'b0011, beats1..3 mask=4'hF, busy low at N+1+4+14.
//  read addr=22'h000010, model returns beat0=32'h1234ABCD after 7 cycles -> dout_out=16'hABCD,
//   busy_out falls 14 cycles after 4th valid beat; addr=22'h000011 -> dout_out=16'h1234.
//  read_in and write_in same cycle -> read issued only, cmd_out=0, overrun_out=1.
//  read with model never asserting valid -> timeout_out=1 after 255 cycles, dout_out unchanged,
//   busy_out falls after gap; next write completes normally.
//  resetn pulsed low during WR_BURST beat 2 -> all outputs at reset values, INIT re-entered.

Source files
------------

// File: rtl/psram_req_responder_if.sv
// Signal bundle between the clk32-side requester, the responder and the PSRAM controller.
// The slave modport is the responder's view; the master modport is everything around it.
interface psram_req_responder_if;
  // requester side
  logic        read_in;
  logic        write_in;
  logic [21:0] addr_in;
  logic [15:0] din_in;
  logic        busy_out;
  logic [15:0] dout_out;
  logic        overrun_out;
  logic        timeout_out;
  // controller side
  logic        calib_in;
  logic        cmd_out;
  logic        cmd_en_out;
  logic [20:0] ctl_addr_out;
  logic [31:0] wr_data_out;
  logic [3:0]  data_mask_out;
  logic [31:0] rd_data_in;
  logic        rd_data_valid_in;

  modport slave (
    input  read_in, write_in, addr_in, din_in, calib_in, rd_data_in, rd_data_valid_in,
    output busy_out, dout_out, overrun_out, timeout_out,
    output cmd_out, cmd_en_out, ctl_addr_out, wr_data_out, data_mask_out
  );

  modport master (
    output read_in, write_in, addr_in, din_in, calib_in, rd_data_in, rd_data_valid_in,
    input  busy_out, dout_out, overrun_out, timeout_out,
    input  cmd_out, cmd_en_out, ctl_addr_out, wr_data_out, data_mask_out
  );
endinterface

// File: rtl/psram_req_responder.sv
// Turns one-cycle 16-bit read/write strobes into single burst commands on a 32-bit
// PSRAM controller port, holding busy_out for the whole transaction plus a fixed gap.
module psram_req_responder #(
  parameter int BURST_BEATS = 4,
  parameter int CMD_GAP     = 14,
  parameter int RD_TIMEOUT  = 255
) (
  input  logic                   clk64,
  input  logic                   resetn,
  psram_req_responder_if.slave   bus
);

  localparam int GAP_W = $clog2(CMD_GAP + 1);
  localparam logic [2:0]       LAST_BEAT   = 3'(BURST_BEATS - 1);
  localparam logic [7:0]       TIMEOUT_CNT = 8'(RD_TIMEOUT);
  localparam logic [GAP_W-1:0] LAST_GAP    = GAP_W'(CMD_GAP - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WR_BURST,
    S_RD_WAIT,
    S_RD_BURST,
    S_GAP
  } state_e;

  state_e state, state_nxt;

  logic [2:0]       beat_cnt;
  logic [7:0]       rd_timer;
  logic [GAP_W-1:0] gap_cnt;
  logic             half_sel;
  logic             cmd_q;
  logic [20:0]      ctl_addr_q;
  logic [31:0]      wr_data_q;
  logic [15:0]      dout_q;
  logic             overrun_q;
  logic             timeout_q;

  logic strobe, take_rd, take_wr;

  assign strobe  = bus.read_in | bus.write_in;
  // Read wins a same-cycle collision; the dropped write is flagged as an overrun.
  assign take_rd = (state == S_IDLE) && bus.read_in;
  assign take_wr = (state == S_IDLE) && bus.write_in && !bus.read_in;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk64 or negedge resetn) begin
    if (!resetn) state <= S_INIT;
    else         state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the case leaves state_nxt
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_INIT:     if (bus.calib_in) state_nxt = S_IDLE;
      S_IDLE:     if (take_rd) state_nxt = S_RD_WAIT;
                  else if (take_wr) state_nxt = S_WR_BURST;
      S_WR_BURST: if (beat_cnt == LAST_BEAT) state_nxt = S_GAP;
      S_RD_WAIT:  if (bus.rd_data_valid_in) state_nxt = S_RD_BURST;
                  else if (rd_timer == TIMEOUT_CNT) state_nxt = S_GAP;
      S_RD_BURST: if (bus.rd_data_valid_in && beat_cnt == LAST_BEAT) state_nxt = S_GAP;
      S_GAP:      if (gap_cnt == LAST_GAP) state_nxt = S_IDLE;
      default:    state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    bus.busy_out      = (state != S_IDLE);
    bus.cmd_en_out    = ((state == S_WR_BURST) && (beat_cnt == 3'd0)) ||
                        ((state == S_RD_WAIT)  && (rd_timer == 8'd0));
    bus.data_mask_out = 4'hF;
    if (state == S_WR_BURST && beat_cnt == 3'd0)
      bus.data_mask_out = half_sel ? 4'b0011 : 4'b1100;
  end

  // Sequence counters: beat_cnt counts write beats or valid read beats,
  // rd_timer measures the wait for the first read beat, gap_cnt the idle gap.
  always_ff @(posedge clk64 or negedge resetn) begin
    if (!resetn) begin
      beat_cnt <= '0;
      rd_timer <= '0;
      gap_cnt  <= '0;
    end else begin
      rd_timer <= (state == S_RD_WAIT) ? rd_timer + 8'd1 : 8'd0;
      gap_cnt  <= (state == S_GAP) ? gap_cnt + GAP_W'(1) : '0;
      unique case (state)
        S_WR_BURST: beat_cnt <= beat_cnt + 3'd1;
        S_RD_WAIT:  beat_cnt <= bus.rd_data_valid_in ? 3'd1 : 3'd0;
        S_RD_BURST: if (bus.rd_data_valid_in) beat_cnt <= beat_cnt + 3'd1;
        default:    beat_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk64 or negedge resetn) begin
    if (!resetn) begin
      half_sel   <= 1'b0;
      cmd_q      <= 1'b0;
      ctl_addr_q <= '0;
      wr_data_q  <= '0;
      dout_q     <= '0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (take_rd || take_wr) begin
        half_sel   <= bus.addr_in[0];
        cmd_q      <= take_wr;
        ctl_addr_q <= bus.addr_in[21:1];
      end
      if (take_wr)
        wr_data_q <= {bus.din_in, bus.din_in};
      if ((state != S_IDLE && strobe) || (state == S_IDLE && bus.read_in && bus.write_in))
        overrun_q <= 1'b1;
      if (state == S_RD_WAIT && bus.rd_data_valid_in)
        dout_q <= half_sel ? bus.rd_data_in[31:16] : bus.rd_data_in[15:0];
      if (state == S_RD_WAIT && !bus.rd_data_valid_in && rd_timer == TIMEOUT_CNT)
        timeout_q <= 1'b1;
    end
  end

  assign bus.cmd_out      = cmd_q;
  assign bus.ctl_addr_out = ctl_addr_q;
  assign bus.wr_data_out  = wr_data_q;
  assign bus.dout_out     = dout_q;
  assign bus.overrun_out  = overrun_q;
  assign bus.timeout_out  = timeout_q;

endmodule
